// File: rtl/conv_encoder_punct.sv
// rtl/conv_encoder_punct.sv - K=7 convolutional encoder with 802.11 puncturing; tail flush selected by CONV_ENCODER_TAIL_EN
module conv_encoder_punct #(
    parameter int WIDTH = 24,
    parameter int CW    = $clog2(2*WIDTH+1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic [3:0]           s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [2*WIDTH-1:0]   m_axis_tdata,
    output logic [CW-1:0]        m_axis_tcount,
    output logic [3:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam logic [1:0] PM_HALF   = 2'd0;
    localparam logic [1:0] PM_TWO3   = 2'd1;
    localparam logic [1:0] PM_THREE4 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // Rate code to puncturing mode: 9/18/36/54M are 3/4, 48M is 2/3, the rest 1/2.
    function automatic logic [1:0] f_mode(input logic [3:0] rate);
        logic [1:0] m;
        case (rate)
            4'b1111, 4'b1110, 4'b1101, 4'b1100: m = PM_THREE4;
            4'b1000:                            m = PM_TWO3;
            default:                            m = PM_HALF;
        endcase
        return m;
    endfunction

    // Coded bit count for a full data beat or for the 6-bit tail.
    function automatic logic [CW-1:0] f_count(input logic [1:0] mode, input logic tail);
        logic [CW-1:0] c;
        if (tail) begin
            case (mode)
                PM_TWO3:   c = CW'(9);
                PM_THREE4: c = CW'(8);
                default:   c = CW'(12);
            endcase
        end else begin
            case (mode)
                PM_TWO3:   c = CW'(3*WIDTH/2);
                PM_THREE4: c = CW'(4*WIDTH/3);
                default:   c = CW'(2*WIDTH);
            endcase
        end
        return c;
    endfunction

    // Pack the A/B streams LSB-first, dropping the punctured positions.
    // Unused high bits stay zero because a/b are zero beyond the valid bits.
    function automatic logic [2*WIDTH-1:0] f_punct(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [1:0]       mode);
        logic [2*WIDTH-1:0] o;
        o = '0;
        case (mode)
            PM_TWO3: begin
                for (int p = 0; p < WIDTH/2; p++) begin
                    o[3*p]   = a[2*p];
                    o[3*p+1] = b[2*p];
                    o[3*p+2] = a[2*p+1];
                end
            end
            PM_THREE4: begin
                for (int t = 0; t < WIDTH/3; t++) begin
                    o[4*t]   = a[3*t];
                    o[4*t+1] = b[3*t];
                    o[4*t+2] = a[3*t+1];
                    o[4*t+3] = b[3*t+2];
                end
            end
            default: begin
                for (int k = 0; k < WIDTH; k++) begin
                    o[2*k]   = a[k];
                    o[2*k+1] = b[k];
                end
            end
        endcase
        return o;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_hist;          // r_hist[5] is the most recent bit
    logic [3:0]         r_rate;
    logic               r_s_tready;

    logic               r_m_tvalid;
    logic [2*WIDTH-1:0] r_m_tdata;
    logic [CW-1:0]      r_m_tcount;
    logic [3:0]         r_m_tuser;
    logic               r_m_tlast;

    logic               r_skid_valid;
    logic [2*WIDTH-1:0] r_skid_tdata;
    logic [CW-1:0]      r_skid_tcount;
    logic [3:0]         r_skid_tuser;
    logic               r_skid_tlast;

    logic               w_in_hs;
    logic               w_out_free;
    logic               w_tail_gen;
    logic               w_new;
    logic               w_skid_nxt;
    logic [3:0]         w_rate;
    logic [1:0]         w_mode;
    logic [WIDTH+5:0]   w_x;
    logic [11:0]        w_xt;
    logic [WIDTH-1:0]   w_a_data;
    logic [WIDTH-1:0]   w_b_data;
    logic [5:0]         w_a_tail;
    logic [5:0]         w_b_tail;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;
    logic [2*WIDTH-1:0] w_new_tdata;
    logic [CW-1:0]      w_new_tcount;
    logic               w_new_tlast;

    assign w_in_hs    = s_axis_tvalid & r_s_tready;
    assign w_out_free = ~r_m_tvalid | m_axis_tready;

`ifdef CONV_ENCODER_TAIL_EN
    // The tail beat needs a free slot; the skid is the only place that can be full.
    assign w_tail_gen  = (r_state == ST_TAIL) & ~r_skid_valid;
    assign w_new_tlast = w_tail_gen;
`else
    assign w_tail_gen  = 1'b0;
    assign w_new_tlast = s_axis_tlast;
`endif

    assign w_new      = w_in_hs | w_tail_gen;
    assign w_skid_nxt = w_out_free ? 1'b0 : (r_skid_valid | w_new);

    // The first beat of a packet uses its own rate; later beats use the latched one.
    assign w_rate = (r_state == ST_IDLE) ? s_axis_tuser : r_rate;
    assign w_mode = f_mode(w_rate);

    // Extended bitstream: history below, current beat above, oldest bit at index 0.
    assign w_x  = {s_axis_tdata, r_hist};
    assign w_xt = {6'd0, r_hist};

    // Generator outputs: A = 133 octal (delays 0,2,3,5,6), B = 171 octal (delays 0,1,2,3,6).
    always_comb begin
        w_a_data = '0;
        w_b_data = '0;
        w_a_tail = '0;
        w_b_tail = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_a_data[k] = w_x[k+6] ^ w_x[k+4] ^ w_x[k+3] ^ w_x[k+1] ^ w_x[k];
            w_b_data[k] = w_x[k+6] ^ w_x[k+5] ^ w_x[k+4] ^ w_x[k+3] ^ w_x[k];
        end
        for (int j = 0; j < 6; j++) begin
            w_a_tail[j] = w_xt[j+6] ^ w_xt[j+4] ^ w_xt[j+3] ^ w_xt[j+1] ^ w_xt[j];
            w_b_tail[j] = w_xt[j+6] ^ w_xt[j+5] ^ w_xt[j+4] ^ w_xt[j+3] ^ w_xt[j];
        end
    end

    assign w_a_sel      = w_tail_gen ? WIDTH'(w_a_tail) : w_a_data;
    assign w_b_sel      = w_tail_gen ? WIDTH'(w_b_tail) : w_b_data;
    assign w_new_tdata  = f_punct(w_a_sel, w_b_sel, w_mode);
    assign w_new_tcount = f_count(w_mode, w_tail_gen);

    // Packet state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packet next-state: track start/middle of packet and the pending tail beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_BODY: begin
                if (w_in_hs) begin
                    if (s_axis_tlast) begin
`ifdef CONV_ENCODER_TAIL_EN
                        w_state_nxt = ST_TAIL;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_TAIL: begin
                if (w_tail_gen) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Encoder history and rate latch; history is kept for the tail and cleared once the packet is done.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_hist <= '0;
            r_rate <= '0;
        end else if (w_in_hs) begin
            if (r_state == ST_IDLE) begin
                r_rate <= s_axis_tuser;
            end
`ifdef CONV_ENCODER_TAIL_EN
            r_hist <= s_axis_tdata[WIDTH-1 -: 6];
`else
            r_hist <= s_axis_tlast ? 6'd0 : s_axis_tdata[WIDTH-1 -: 6];
`endif
        end else if (w_tail_gen) begin
            r_hist <= '0;
        end
    end

    // Output register plus skid entry; the skid refills the output before any new beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s_tready    <= 1'b0;
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_m_tcount    <= '0;
            r_m_tuser     <= '0;
            r_m_tlast     <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_tdata  <= '0;
            r_skid_tcount <= '0;
            r_skid_tuser  <= '0;
            r_skid_tlast  <= 1'b0;
        end else begin
            r_s_tready <= ~w_skid_nxt & (w_state_nxt != ST_TAIL);
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_m_tvalid   <= 1'b1;
                    r_m_tdata    <= r_skid_tdata;
                    r_m_tcount   <= r_skid_tcount;
                    r_m_tuser    <= r_skid_tuser;
                    r_m_tlast    <= r_skid_tlast;
                    r_skid_valid <= 1'b0;
                end else if (w_new) begin
                    r_m_tvalid <= 1'b1;
                    r_m_tdata  <= w_new_tdata;
                    r_m_tcount <= w_new_tcount;
                    r_m_tuser  <= w_rate;
                    r_m_tlast  <= w_new_tlast;
                end else begin
                    r_m_tvalid <= 1'b0;
                end
            end else if (w_new) begin
                r_skid_valid  <= 1'b1;
                r_skid_tdata  <= w_new_tdata;
                r_skid_tcount <= w_new_tcount;
                r_skid_tuser  <= w_rate;
                r_skid_tlast  <= w_new_tlast;
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tcount = r_m_tcount;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// tb/tb_conv_encoder_punct.sv - self-checking bench for conv_encoder_punct
module tb_conv_encoder_punct;

    localparam int W = 24;
`ifdef CONV_ENCODER_TAIL_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef struct packed {
        logic [47:0] d;
        logic [5:0]  c;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  s_axis_tdata = '0;
    logic [3:0]    s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [47:0]   m_axis_tdata;
    logic [5:0]    m_axis_tcount;
    logic [3:0]    m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;

    conv_encoder_punct dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tcount (m_axis_tcount),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    int    n_total = 0;
    int    n_pass  = 0;
    beat_t exp_q[$];
    beat_t cap_q[$];
    bit    rdy_rand = 1'b0;

    logic [3:0] codes [8] = '{4'b1011, 4'b1111, 4'b1010, 4'b1110,
                              4'b1001, 4'b1101, 4'b1000, 4'b1100};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic int rate_kind(input logic [3:0] r);
        case (r)
            4'b1111, 4'b1110, 4'b1101, 4'b1100: return 2;
            4'b1000:                            return 1;
            default:                            return 0;
        endcase
    endfunction

    // Bit-serial reference: shift each bit through a 7-bit window, parity against
    // the generator masks, then drop coded bits by the puncturing pattern.
    task automatic model_enc(input logic [23:0] d, input int nbits, input logic [3:0] rate,
                             input logic [6:0] sr_in, output logic [6:0] sr_out,
                             output logic [47:0] o, output int cnt);
        logic [6:0] s;
        logic       c [48];
        int         kind;
        bit         keep;
        s = sr_in;
        for (int i = 0; i < nbits; i++) begin
            s = {s[5:0], d[i]};
            c[2*i]   = ^(s & 7'h6D);
            c[2*i+1] = ^(s & 7'h4F);
        end
        kind = rate_kind(rate);
        o = '0;
        cnt = 0;
        for (int j = 0; j < 2*nbits; j++) begin
            if (kind == 0)      keep = 1'b1;
            else if (kind == 1) keep = (j % 4) != 3;
            else                keep = ((j % 6) <= 2) || ((j % 6) == 5);
            if (keep) begin
                o[cnt] = c[j];
                cnt++;
            end
        end
        sr_out = s;
    endtask

    logic [6:0] m_sr = '0;
    logic [3:0] m_rate = '0;
    bit         m_inpkt = 1'b0;

    task automatic model_beat(input logic [23:0] d, input logic [3:0] u, input logic l);
        logic [6:0]  s2;
        logic [47:0] o;
        int          cnt;
        if (!m_inpkt) begin
            m_rate  = u;
            m_inpkt = 1'b1;
        end
        model_enc(d, 24, m_rate, m_sr, s2, o, cnt);
        m_sr = s2;
        if (!l) begin
            exp_q.push_back('{o, 6'(cnt), m_rate, 1'b0});
        end else begin
`ifdef CONV_ENCODER_TAIL_EN
            exp_q.push_back('{o, 6'(cnt), m_rate, 1'b0});
            model_enc(24'd0, 6, m_rate, m_sr, s2, o, cnt);
            exp_q.push_back('{o, 6'(cnt), m_rate, 1'b1});
`else
            exp_q.push_back('{o, 6'(cnt), m_rate, 1'b1});
`endif
            m_sr    = '0;
            m_inpkt = 1'b0;
        end
    endtask

    // m_axis_tready driver.
    initial begin
        forever begin
            @(negedge aclk);
            m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: sampled 2 time units after each falling edge.
    bit    prev_rst = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_out;
    initial begin
        beat_t e;
        beat_t a;
        forever begin
            @(negedge aclk);
            #2;
            a = '{m_axis_tdata, m_axis_tcount, m_axis_tuser, m_axis_tlast};
            if (!aresetn) begin
                exp_q.delete();
                m_sr = '0;
                m_inpkt = 1'b0;
                if (prev_rst) begin
                    chk("rst_m_tvalid", m_axis_tvalid, 0);
                    chk("rst_m_tdata",  m_axis_tdata, 0);
                    chk("rst_m_tcount", m_axis_tcount, 0);
                    chk("rst_m_tuser",  m_axis_tuser, 0);
                    chk("rst_m_tlast",  m_axis_tlast, 0);
                    chk("rst_s_tready", s_axis_tready, 0);
                end
                prev_rst = 1'b1;
                prev_stall = 1'b0;
            end else begin
                prev_rst = 1'b0;
                if (prev_stall) begin
                    chk("stall_stable", {m_axis_tvalid, a}, {1'b1, prev_out});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_tdata",  a.d, e.d);
                        chk("out_tcount", a.c, e.c);
                        chk("out_tuser",  a.u, e.u);
                        chk("out_tlast",  a.l, e.l);
                    end
                    cap_q.push_back(a);
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_out = a;
                if (s_axis_tvalid && s_axis_tready)
                    model_beat(s_axis_tdata, s_axis_tuser, s_axis_tlast);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send_beat(input logic [23:0] d, input logic [3:0] u, input logic l, input int gap);
        int n;
        bit ok;
        s_axis_tvalid = 1'b0;
        repeat (gap) @(negedge aclk);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 500) begin
            #1;
            ok = s_axis_tready;
            @(negedge aclk);
            n++;
        end
        s_axis_tvalid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_cap(input int n);
        int k;
        k = 0;
        while (cap_q.size() < n && k < 300) begin
            @(negedge aclk);
            #3;
            k++;
        end
        chk("cap_count", cap_q.size(), n);
        @(negedge aclk);
    endtask

    task automatic drain();
        int k;
        rdy_rand = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge aclk);
            k++;
        end
        repeat (10) @(negedge aclk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [6:0]  s1;
        logic [6:0]  s2;
        logic [47:0] o;
        int          cnt;
        int          sent;
        int          len;
        logic [3:0]  u;
        bit          l;

        // Pin the reference model with hand-computed codewords.
        model_enc(24'h000001, 24, 4'b1011, 7'd0, s1, o, cnt);
        chk("pin_6m_data", o, 48'h34FB);
        chk("pin_6m_cnt", cnt, 48);
        model_enc(24'h000001, 24, 4'b1100, 7'd0, s1, o, cnt);
        chk("pin_54m_data", o, 48'h33B);
        chk("pin_54m_cnt", cnt, 32);
        model_enc(24'h000001, 24, 4'b1000, 7'd0, s1, o, cnt);
        chk("pin_48m_data", o, 48'h73B);
        chk("pin_48m_cnt", cnt, 36);
        model_enc(24'h800000, 24, 4'b1011, 7'd0, s1, o, cnt);
        chk("pin_msb_data", o, 48'hC000_0000_0000);
        model_enc(24'd0, 6, 4'b1011, s1, s2, o, cnt);
        chk("pin_tail_data", o, 48'hD3E);
        chk("pin_tail_cnt", cnt, 12);

        aresetn = 1'b0;
        repeat (4) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        chk("tready_after_reset", s_axis_tready, 1);
        @(negedge aclk);

        cap_q.delete();
        send_beat(24'h000001, 4'b1011, 1'b1, 0);
        wait_cap(NB);
        if (cap_q.size() >= 1) begin
            chk("dir_6m_data", cap_q[0].d, 48'h34FB);
            chk("dir_6m_cnt", cap_q[0].c, 48);
            chk("dir_6m_last", cap_q[0].l, NB == 1);
        end

        cap_q.delete();
        send_beat(24'h000001, 4'b1100, 1'b1, 0);
        wait_cap(NB);
        if (cap_q.size() >= 1) begin
            chk("dir_54m_data", cap_q[0].d, 48'h33B);
            chk("dir_54m_cnt", cap_q[0].c, 32);
            chk("dir_54m_user", cap_q[0].u, 4'b1100);
        end

        cap_q.delete();
        send_beat(24'h800000, 4'b1011, 1'b1, 0);
        wait_cap(NB);
        if (cap_q.size() >= 1) begin
            chk("dir_msb_data", cap_q[0].d, 48'hC000_0000_0000);
            chk("dir_msb_cnt", cap_q[0].c, 48);
            chk("dir_msb_last", cap_q[0].l, NB == 1);
        end
`ifdef CONV_ENCODER_TAIL_EN
        if (cap_q.size() >= 2) begin
            chk("dir_tail_data", cap_q[1].d, 48'hD3E);
            chk("dir_tail_cnt", cap_q[1].c, 12);
            chk("dir_tail_last", cap_q[1].l, 1);
        end
`endif

        // Rate changes mid-packet must not affect tuser of later beats.
        cap_q.delete();
        send_beat(24'h123456, 4'b1000, 1'b0, 0);
        send_beat(24'h654321, 4'b1011, 1'b0, 0);
        send_beat(24'hABCDEF, 4'b1100, 1'b1, 0);
        wait_cap(2 + NB);
        if (cap_q.size() >= 3) begin
            chk("midrate_user1", cap_q[1].u, 4'b1000);
            chk("midrate_user2", cap_q[2].u, 4'b1000);
            chk("midrate_cnt2", cap_q[2].c, 36);
        end

        // Random traffic with 50% output backpressure.
        rdy_rand = 1'b1;
        sent = 0;
        while (sent < 1000) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len && sent < 1000; b++) begin
                l = (b == len - 1) || (sent == 999);
                u = ($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
                send_beat(24'($urandom), u, l, ($urandom_range(0, 3) == 0) ? 1 : 0);
                sent++;
            end
        end
        drain();

        // Reset in the middle of a packet; the next packet starts from zero history.
        rdy_rand = 1'b1;
        send_beat(24'hFFFFFF, 4'b1100, 1'b0, 0);
        send_beat(24'hF0F0F0, 4'b1100, 1'b0, 0);
        aresetn = 1'b0;
        rdy_rand = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        chk("tready_after_midreset", s_axis_tready, 1);
        @(negedge aclk);
        cap_q.delete();
        send_beat(24'h000001, 4'b1011, 1'b1, 0);
        wait_cap(NB);
        if (cap_q.size() >= 1) begin
            chk("post_reset_data", cap_q[0].d, 48'h34FB);
            chk("post_reset_user", cap_q[0].u, 4'b1011);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
